// File: rtl/scan_seq_pkg.sv
// Shared state encodings, focal-zone codes and the zone-to-code mapping for the scan line sequencer.
// Pure declarations: no latency, no flow control.
package scan_seq_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ENV  = 3'd1;
   localparam logic [2:0] ST_GAP  = 3'd2;
   localparam logic [2:0] ST_GATE = 3'd3;
   localparam logic [2:0] ST_LEND = 3'd4;

   localparam logic [1:0] ZONE0 = 2'b10;
   localparam logic [1:0] ZONE1 = 2'b11;
   localparam logic [1:0] ZONE2 = 2'b00;

   function automatic logic [1:0] zone_code(input logic [1:0] zone);
      logic [1:0] code;
      case (zone)
         2'd0:    code = ZONE0;
         2'd1:    code = ZONE1;
         default: code = ZONE2;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seq_interval_timer.sv
// Loadable down-counter timing one sequencer phase; a zero length is run as one cycle.
// last is high in the final cycle of the loaded interval; last_nxt predicts it one cycle early.
module seq_interval_timer #(
   parameter int TIME_W = 16
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   output logic              last,
   output logic              last_nxt
);

   logic [TIME_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = (load_val == '0) ? TIME_W'(1) : load_val;
      end else if (count_q > TIME_W'(1)) begin
         count_d = count_q - TIME_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last     = (count_q == TIME_W'(1));
   assign last_nxt = (count_d == TIME_W'(1));

endmodule

// File: rtl/scan_line_sequencer.sv
// Per-frame envelop / rx_gate sequencer: one envelop pulse then one gate per focal zone, each line.
// Outputs registered, busy/envelop one cycle after start; no backpressure, stop ends after current line.
module scan_line_sequencer
   import scan_seq_pkg::*;
#(
   parameter int LINE_W = 8,
   parameter int TIME_W = 16
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic [LINE_W-1:0] cfg_lines,
   input  logic [1:0]        cfg_zones,
   input  logic [TIME_W-1:0] cfg_env_len,
   input  logic [TIME_W-1:0] cfg_gap_len,
   input  logic [TIME_W-1:0] cfg_gate_len,
   output logic              busy,
   output logic              envelop,
   output logic              rx_gate,
   output logic [1:0]        focus_num,
   output logic [LINE_W-1:0] line_num,
   output logic              line_done,
   output logic              frame_done
);

   typedef struct packed {
      logic [LINE_W-1:0] lines;
      logic [1:0]        zones;
      logic [TIME_W-1:0] env_len;
      logic [TIME_W-1:0] gap_len;
      logic [TIME_W-1:0] gate_len;
   } cfg_t;

   logic [2:0]        state_q, state_d;
   cfg_t              cfg_q, cfg_d;
   logic [1:0]        zone_q, zone_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              stop_pend_q, stop_pend_d;
   logic              busy_q, busy_d, env_q, env_d, gate_q, gate_d;
   logic              line_done_q, line_done_d, frame_done_q, frame_done_d;
   logic [1:0]        focus_q, focus_d;
   logic              tmr_load, tmr_last, tmr_last_nxt, last_line;
   logic [TIME_W-1:0] tmr_val;

   seq_interval_timer #(.TIME_W(TIME_W)) u_timer (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .last     (tmr_last),
      .last_nxt (tmr_last_nxt)
   );

   assign last_line = (line_q == cfg_q.lines - LINE_W'(1));

   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      zone_d      = zone_q;
      line_d      = line_q;
      stop_pend_d = stop_pend_q | stop;
      tmr_load    = 1'b0;
      tmr_val     = cfg_q.gap_len;
      case (state_q)
         ST_IDLE: begin
            stop_pend_d = 1'b0;
            if (start) begin
               cfg_d.lines    = (cfg_lines == '0) ? LINE_W'(1) : cfg_lines;
               cfg_d.zones    = (cfg_zones == 2'd0) ? 2'd1 : cfg_zones;
               cfg_d.env_len  = cfg_env_len;
               cfg_d.gap_len  = cfg_gap_len;
               cfg_d.gate_len = cfg_gate_len;
               zone_d         = 2'd0;
               line_d         = '0;
               state_d        = ST_ENV;
               tmr_load       = 1'b1;
               tmr_val        = cfg_env_len;
            end
         end
         ST_ENV: begin
            if (tmr_last) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
            end
         end
         ST_GAP: begin
            if (tmr_last) begin
               state_d  = ST_GATE;
               tmr_load = 1'b1;
               tmr_val  = cfg_q.gate_len;
            end
         end
         ST_GATE: begin
            if (tmr_last) begin
               tmr_load = 1'b1;
               if (zone_q == cfg_q.zones - 2'd1) begin
                  state_d = ST_LEND;
               end else begin
                  zone_d  = zone_q + 2'd1;
                  state_d = ST_GAP;
               end
            end
         end
         ST_LEND: begin
            // A stop seen in this very cycle still prevents the next line.
            if (tmr_last) begin
               if (last_line || stop_pend_q || stop) begin
                  state_d = ST_IDLE;
               end else begin
                  line_d   = line_q + LINE_W'(1);
                  zone_d   = 2'd0;
                  state_d  = ST_ENV;
                  tmr_load = 1'b1;
                  tmr_val  = cfg_q.env_len;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_IDLE) begin
         stop_pend_d = 1'b0;
      end
   end

   // Strobes are registered from the next state so they line up with the state they describe.
   always_comb begin
      busy_d       = (state_d != ST_IDLE);
      env_d        = (state_d == ST_ENV);
      gate_d       = (state_d == ST_GATE);
      line_done_d  = (state_d == ST_LEND) && tmr_last_nxt;
      frame_done_d = line_done_d && last_line;
      focus_d      = focus_q;
      if (state_d == ST_ENV) begin
         focus_d = 2'b00;
      end else if (state_d == ST_GATE && state_q != ST_GATE) begin
         focus_d = zone_code(zone_q);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cfg_q        <= '0;
         zone_q       <= 2'd0;
         line_q       <= '0;
         stop_pend_q  <= 1'b0;
         busy_q       <= 1'b0;
         env_q        <= 1'b0;
         gate_q       <= 1'b0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         focus_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         zone_q       <= zone_d;
         line_q       <= line_d;
         stop_pend_q  <= stop_pend_d;
         busy_q       <= busy_d;
         env_q        <= env_d;
         gate_q       <= gate_d;
         line_done_q  <= line_done_d;
         frame_done_q <= frame_done_d;
         focus_q      <= focus_d;
      end
   end

   assign busy       = busy_q;
   assign envelop    = env_q;
   assign rx_gate    = gate_q;
   assign focus_num  = focus_q;
   assign line_num   = line_q;
   assign line_done  = line_done_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_line_sequencer.sv
// Bench for scan_line_sequencer: table of frame scenarios, reset-mid-frame sequence, randomized frames.
// Expected per-cycle outputs are generated from the line/zone timing rules, not from the FSM.
module tb_scan_line_sequencer;

   localparam int LINE_W = 8;
   localparam int TIME_W = 16;

   logic              clk_in = 1'b0;
   logic              reset_n, start, stop;
   logic [LINE_W-1:0] cfg_lines;
   logic [1:0]        cfg_zones;
   logic [TIME_W-1:0] cfg_env_len, cfg_gap_len, cfg_gate_len;
   logic              busy, envelop, rx_gate, line_done, frame_done;
   logic [1:0]        focus_num;
   logic [LINE_W-1:0] line_num;

   typedef struct packed {
      logic              busy;
      logic              env;
      logic              gate;
      logic [1:0]        focus;
      logic [LINE_W-1:0] line;
      logic              ld;
      logic              fd;
   } out_t;

   typedef struct {
      int l, z, e, g, w, stop_at, scr, ss;
      int x_busy, x_ld, x_fd, x_fdcyc, x_line;
   } vec_t;

   int         n_cmp = 0;
   int         n_err = 0;
   out_t       exp_q[$];
   out_t       idle_exp;
   out_t       act;
   logic [1:0] code_tab [3] = '{2'b10, 2'b11, 2'b00};
   vec_t       tab [7];

   scan_line_sequencer #(.LINE_W(LINE_W), .TIME_W(TIME_W)) dut (
      .clk_in       (clk_in),
      .reset_n      (reset_n),
      .start        (start),
      .stop         (stop),
      .cfg_lines    (cfg_lines),
      .cfg_zones    (cfg_zones),
      .cfg_env_len  (cfg_env_len),
      .cfg_gap_len  (cfg_gap_len),
      .cfg_gate_len (cfg_gate_len),
      .busy         (busy),
      .envelop      (envelop),
      .rx_gate      (rx_gate),
      .focus_num    (focus_num),
      .line_num     (line_num),
      .line_done    (line_done),
      .frame_done   (frame_done)
   );

   always #5 clk_in = ~clk_in;

   assign act = {busy, envelop, rx_gate, focus_num, line_num, line_done, frame_done};

   task automatic check(input string name, input int idx, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, a, e);
      end
   endtask

   function automatic out_t mk(input logic b, input logic en, input logic g, input logic [1:0] f,
                               input int li, input logic ld, input logic fd);
      out_t o;
      o.busy = b; o.env = en; o.gate = g; o.focus = f;
      o.line = LINE_W'(li); o.ld = ld; o.fd = fd;
      return o;
   endfunction

   // Called just after a rising edge; cycle 0 carries the start pulse and checks the idle outputs.
   task automatic run_frame(input int l, input int z, input int e, input int g, input int w,
                            input int stop_at, input int scr, input int ss,
                            output int nb, output int nld, output int nfd, output int fdc, output int lastl);
      int L, Z, E, G, W, P, nl;
      logic [1:0] foc;
      out_t idle_next;
      L = (l == 0) ? 1 : l;
      Z = (z == 0) ? 1 : z;
      E = (e == 0) ? 1 : e;
      G = (g == 0) ? 1 : g;
      W = (w == 0) ? 1 : w;
      P = E + Z * (G + W) + G;
      nl = L;
      if (stop_at > 0 && (stop_at - 1) / P + 1 < L) nl = (stop_at - 1) / P + 1;
      exp_q.delete();
      foc = 2'b00;
      for (int li = 0; li < nl; li++) begin
         repeat (E) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, li, 1'b0, 1'b0));
         foc = 2'b00;
         for (int zi = 0; zi < Z; zi++) begin
            repeat (G) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, foc, li, 1'b0, 1'b0));
            foc = code_tab[zi];
            repeat (W) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, foc, li, 1'b0, 1'b0));
         end
         for (int k = 0; k < G; k++)
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, foc, li, (k == G - 1), (k == G - 1) && (li == L - 1)));
      end
      idle_next = mk(1'b0, 1'b0, 1'b0, foc, nl - 1, 1'b0, 1'b0);
      nb = 0; nld = 0; nfd = 0; fdc = 0; lastl = 0;
      for (int c = 0; c <= exp_q.size(); c++) begin
         if (c == 0) begin
            start        = 1'b1;
            stop         = (ss != 0);
            cfg_lines    = LINE_W'(l);
            cfg_zones    = 2'(z);
            cfg_env_len  = TIME_W'(e);
            cfg_gap_len  = TIME_W'(g);
            cfg_gate_len = TIME_W'(w);
         end else begin
            start = (scr != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop  = (c == stop_at);
            if (scr != 0) begin
               cfg_lines    = LINE_W'($urandom);
               cfg_zones    = 2'($urandom);
               cfg_env_len  = TIME_W'($urandom);
               cfg_gap_len  = TIME_W'($urandom);
               cfg_gate_len = TIME_W'($urandom);
            end
         end
         @(negedge clk_in);
         if (c == 0) begin
            check("idle_outputs", c, 32'(act), 32'(idle_exp));
         end else begin
            check("frame_trace", c, 32'(act), 32'(exp_q[c-1]));
            nb  += int'(busy);
            nld += int'(line_done);
            if (frame_done) begin
               nfd++;
               fdc = c;
            end
            lastl = int'(line_num);
         end
         @(posedge clk_in);
         #1;
      end
      start    = 1'b0;
      stop     = 1'b0;
      idle_exp = idle_next;
   endtask

   initial begin
      int nb, nld, nfd, fdc, lastl;
      //        L    Z  E  G  W  stop scr ss   busy  ld   fd  fdcyc line
      tab[0] = '{2,   3, 2, 3, 4, 0,   0,  0,  52,   2,   1,  52,   1};
      tab[1] = '{0,   0, 0, 0, 0, 0,   0,  0,  4,    1,   1,  4,    0};
      tab[2] = '{5,   1, 1, 1, 1, 7,   0,  0,  8,    2,   0,  0,    1};
      tab[3] = '{3,   2, 3, 2, 5, 19,  0,  0,  19,   1,   0,  0,    0};
      tab[4] = '{1,   3, 1, 1, 1, 1,   0,  0,  8,    1,   1,  8,    0};
      tab[5] = '{255, 1, 0, 0, 0, 0,   0,  0,  1020, 255, 1,  1020, 254};
      tab[6] = '{3,   2, 1, 2, 1, 0,   1,  1,  27,   3,   1,  27,   2};

      reset_n = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_lines = '0; cfg_zones = '0; cfg_env_len = '0; cfg_gap_len = '0; cfg_gate_len = '0;
      idle_exp = '0;
      repeat (3) @(posedge clk_in);
      #1 reset_n = 1'b1;

      // Frames run back to back: each start lands in the first idle cycle of the previous frame.
      foreach (tab[i]) begin
         run_frame(tab[i].l, tab[i].z, tab[i].e, tab[i].g, tab[i].w, tab[i].stop_at, tab[i].scr, tab[i].ss,
                   nb, nld, nfd, fdc, lastl);
         check("busy_cycles", i, 32'(nb), 32'(tab[i].x_busy));
         check("line_done_count", i, 32'(nld), 32'(tab[i].x_ld));
         check("frame_done_count", i, 32'(nfd), 32'(tab[i].x_fd));
         check("frame_done_cycle", i, 32'(fdc), 32'(tab[i].x_fdcyc));
         check("final_line_num", i, 32'(lastl), 32'(tab[i].x_line));
      end

      // Reset during the first gate of line 3 (line period 6, so cycle 21).
      cfg_lines = 8'd5; cfg_zones = 2'd2; cfg_env_len = 16'd1; cfg_gap_len = 16'd1; cfg_gate_len = 16'd1;
      start = 1'b1;
      @(posedge clk_in); #1 start = 1'b0;
      repeat (20) begin
         @(posedge clk_in);
         #1;
      end
      @(negedge clk_in);
      check("pre_reset_line", 21, 32'(line_num), 32'd3);
      check("pre_reset_gate", 21, 32'(rx_gate), 32'd1);
      reset_n = 1'b0;
      @(posedge clk_in); #1 reset_n = 1'b1;
      @(negedge clk_in);
      check("reset_outputs", 22, 32'(act), 32'd0);
      @(posedge clk_in); #1;
      idle_exp = '0;
      run_frame(2, 2, 1, 1, 1, 0, 0, 0, nb, nld, nfd, fdc, lastl);

      for (int i = 0; i < 40; i++) begin
         int sa;
         sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0;
         run_frame(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), sa,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 4) == 0),
                   nb, nld, nfd, fdc, lastl);
      end

      @(negedge clk_in);
      check("final_idle", 0, 32'(act), 32'(idle_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
